seq_divider_hhrb98: RTL
=======================

Name: seq_divider_hhrb98

Overview:
Iterative restoring divider, the inverse of the team's 4x4 array multiplier. It takes an 8-bit product-width dividend and a 4-bit divisor, and returns an 8-bit quotient and a 4-bit remainder. One quotient bit is resolved per clock, with valid/ready handshakes on input and output. It sits beside the multiplier, so a bench or a higher-level datapath can check products as p / b == a with remainder 0.

Parameters:
DW, 8, dividend and quotient width
VW, 4, divisor and remainder width

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  dividend/divisor presented
in_ready  output  1  block can accept an operation
dividend  input  DW  numerator, unsigned
divisor  input  VW  denominator, unsigned
out_valid  output  1  result available
out_ready  input  1  consumer accepts result
quotient  output  DW  unsigned quotient
remainder  output  VW  unsigned remainder
div_by_zero  output  1  divisor was 0 for this result

Behaviour:
- Clock and reset: one clock, clk. rst_n is asynchronous, active-low.
- Reset values: state=IDLE, in_ready=1, out_valid=0, quotient=0, remainder=0, div_by_zero=0, internal counter=0.
- States: IDLE, RUN, DONE.
- in_ready = (state==IDLE). out_valid = (state==DONE). Both are registered-state decodes, with no combinational path from in_valid or out_ready.
- Accept: a transfer happens on an edge where in_valid && in_ready. The edge latches the dividend into shift register Q, the divisor into D, clears R (VW+1 bits) and clears the count.
  - divisor != 0: go to RUN.
  - divisor == 0: go straight to DONE with quotient=all ones, remainder=0, div_by_zero=1.
- RUN, one iteration per edge:
  - T = {R[VW-1:0], Q[DW-1]}.
  - If T >= {1'b0,D}: R <= T - D and qbit=1; else R <= T and qbit=0.
  - Q <= {Q[DW-2:0], qbit}; count++.
  - The edge where count==DW-1 performs the last iteration and enters DONE.
- Latency: accept at edge k gives out_valid high after edge k+DW (8 cycles). For divide-by-zero, out_valid is high after edge k (1 cycle).
- DONE:
  - quotient=Q and remainder=R[VW-1:0], held stable.
  - div_by_zero is held until release.
  - On an edge with out_ready=1, return to IDLE and clear div_by_zero. quotient/remainder keep their last value.
  - out_ready=0 holds DONE indefinitely with all outputs stable.
- No overlap: a new operation is never accepted in RUN or DONE. in_valid during those states is ignored and not queued.
- Reset mid-operation (RUN or DONE): immediately return to the reset values; the in-flight result is lost, and out_valid never pulses.
- Invariant: R[VW] is always 0 after each iteration. The remainder is always < divisor.
- Arithmetic is unsigned only. No overflow is possible, since the quotient fits DW bits for any divisor >= 1.

Decomposition:
- Package seq_divider_pkg:
  - state enum {IDLE, RUN, DONE};
  - DW/VW defaults;
  - count width constant $clog2(DW).
- Sub-module div_step: purely combinational single restoring iteration. Inputs R, Q msb, D; outputs next R and qbit. It is reusable for a future unrolled/pipelined variant.
- The top holds the FSM, counter, and registers.

Test Plan:
- Reset, then dividend=143, divisor=11 -> out_valid exactly 8 cycles after accept; quotient=13, remainder=0, div_by_zero=0.
- 200/15 -> quotient=13, remainder=5. Then 255/1 -> quotient=255, remainder=0. Then 0/7 -> quotient=0, remainder=0. Run back-to-back, asserting in_valid throughout: in_ready low during RUN/DONE, and each op is accepted exactly once.
- 100/0 -> out_valid 1 cycle after accept; quotient=8'hFF, remainder=0, div_by_zero=1. div_by_zero clears on the release edge.
- Backpressure on 9/2: hold out_ready=0 for 5 cycles -> quotient=4 and remainder=1 stay stable and out_valid stays high. Release -> IDLE next edge, in_ready=1.
- Assert rst_n=0 asynchronously at the 4th RUN cycle of 77/3 -> outputs return to reset values immediately with no out_valid. A subsequent 77/3 -> quotient=25, remainder=2.
- Exhaustive inverse check against the multiplier, for all a in 0..15 and b in 1..15: dividend=a*b, divisor=b -> quotient=a, remainder=0.

Source files
------------

// File: rtl/seq_divider_pkg.sv
// Shared types and sizing for the iterative restoring divider.
package seq_divider_pkg;
  localparam int DW_DEF = 8;
  localparam int VW_DEF = 4;
  localparam int CW_DEF = $clog2(DW_DEF);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;
endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift in the next dividend bit, subtract if it fits.
module div_step #(
  parameter int VW = 4
) (
  input  logic [VW-1:0] r_i,
  input  logic          q_msb_i,
  input  logic [VW-1:0] d_i,
  output logic [VW-1:0] r_o,
  output logic          qbit_o
);
  logic [VW:0] t;

  assign t      = {r_i, q_msb_i};
  assign qbit_o = (t >= {1'b0, d_i});
  // Partial remainder stays below the divisor, so T-D always fits in VW bits.
  assign r_o    = qbit_o ? (t[VW-1:0] - d_i) : t[VW-1:0];
endmodule

// File: rtl/seq_divider_hhrb98.sv
// Sequential restoring divider: one quotient bit per clock, valid/ready on both sides.
module seq_divider_hhrb98
  import seq_divider_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int VW = VW_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] dividend,
  input  logic [VW-1:0] divisor,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] quotient,
  output logic [VW-1:0] remainder,
  output logic          div_by_zero
);
  localparam int            CW   = $clog2(DW);
  localparam logic [CW-1:0] LAST = CW'(DW - 1);

  state_e        state_q, state_d;
  logic [DW-1:0] q_q, quot_q, q_nxt;
  logic [VW-1:0] d_q, r_q, rem_q, r_nxt;
  logic [CW-1:0] cnt_q;
  logic          dbz_q, qbit, accept, last;

  div_step #(.VW(VW)) u_step (
    .r_i     (r_q),
    .q_msb_i (q_q[DW-1]),
    .d_i     (d_q),
    .r_o     (r_nxt),
    .qbit_o  (qbit)
  );

  assign q_nxt  = {q_q[DW-2:0], qbit};
  assign accept = in_valid && (state_q == IDLE);
  assign last   = (state_q == RUN) && (cnt_q == LAST);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid) state_d = (divisor == '0) ? DONE : RUN;
      RUN:     if (cnt_q == LAST) state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      q_q     <= '0;
      d_q     <= '0;
      r_q     <= '0;
      cnt_q   <= '0;
      quot_q  <= '0;
      rem_q   <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        q_q   <= dividend;
        d_q   <= divisor;
        r_q   <= '0;
        cnt_q <= '0;
        if (divisor == '0) begin
          quot_q <= '1;
          rem_q  <= '0;
          dbz_q  <= 1'b1;
        end
      end else if (state_q == RUN) begin
        r_q   <= r_nxt;
        q_q   <= q_nxt;
        cnt_q <= cnt_q + 1'b1;
        // Result registers only move on completion so outputs hold between ops.
        if (last) begin
          quot_q <= q_nxt;
          rem_q  <= r_nxt;
        end
      end else if (state_q == DONE && out_ready) begin
        dbz_q <= 1'b0;
      end
    end
  end

  assign in_ready    = (state_q == IDLE);
  assign out_valid   = (state_q == DONE);
  assign quotient    = quot_q;
  assign remainder   = rem_q;
  assign div_by_zero = dbz_q;
endmodule
